// File: rtl/adder_share_pkg.sv
// Shared helpers for the adder share controller.
// Optional adder self-check is enabled with `define ADD_CHECK_EN.
package adder_share_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int entry_w(input int w, input int idw);
    return w + 1 + idw;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Returns a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one pipelined adder among NREQ clients with credit-guarded result FIFO.
// Define ADD_CHECK_EN to add a shadow operand pipe that flags adder mismatches on err.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int W          = 32,
  parameter int ADD_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int IDW       = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  input  logic [W:0]        add_s,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W:0]        resp_sum,
  output logic [IDW-1:0]    resp_id,
  output logic              err
);

  localparam int CW = clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? clog2(FIFO_DEPTH) : 1;
  localparam int EW = entry_w(W, IDW);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gidx;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic [CW-1:0]   occ;
  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            pop;
  logic [W-1:0]    ga;
  logic [W-1:0]    gb;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gidx),
    .any(any)
  );

  assign credit_ok = (occ < CW'(FIFO_DEPTH));
  assign issue     = any & credit_ok;
  assign req_ready = credit_ok ? gnt : '0;
  assign ga        = req_a[gidx*W +: W];
  assign gb        = req_b[gidx*W +: W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      add_x <= '0;
      add_y <= '0;
    end else if (issue) begin
      add_x <= ga;
      add_y <= gb;
      ptr   <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Tag pipe tracks which cycle add_s belongs to a granted request.
  logic [ADD_LAT-1:0] tv;
  logic [IDW-1:0]     tid [ADD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv <= '0;
      for (int i = 0; i < ADD_LAT; i++) tid[i] <= '0;
    end else begin
      tv[0]  <= issue;
      tid[0] <= gidx;
      for (int i = 1; i < ADD_LAT; i++) begin
        tv[i]  <= tv[i-1];
        tid[i] <= tid[i-1];
      end
    end
  end

  assign push = tv[ADD_LAT-1];
  assign pop  = resp_valid & resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ <= '0;
    else     occ <= occ + CW'(issue) - CW'(pop);
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [EW-1:0] head;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {add_s, tid[ADD_LAT-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push)
        wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop)
        rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign head       = mem[rp];
  assign resp_valid = (cnt != '0);
  assign resp_sum   = resp_valid ? head[EW-1:IDW] : '0;
  assign resp_id    = resp_valid ? head[IDW-1:0] : '0;

`ifdef ADD_CHECK_EN
  logic [W-1:0] sx [ADD_LAT];
  logic [W-1:0] sy [ADD_LAT];
  logic [W:0]   chk;
  logic         err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ADD_LAT; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
    end else begin
      if (issue) begin
        sx[0] <= ga;
        sy[0] <= gb;
      end
      for (int i = 1; i < ADD_LAT; i++) begin
        sx[i] <= sx[i-1];
        sy[i] <= sy[i-1];
      end
    end
  end

  assign chk = {1'b0, sx[ADD_LAT-1]} + {1'b0, sy[ADD_LAT-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err_r <= 1'b0;
    else if (push && chk != add_s) err_r <= 1'b1;
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule
